// File: rtl/dcache_nway_pkg.sv
// Shared types for the n-way data cache.
// Line widths depend on instance parameters, so they live in the modules.
package cache_def;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cpu_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
  } cpu_result_t;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [31:0] addr;
  } mem_req_t;

endpackage

// File: rtl/dcache_nway_plru.sv
// Per-set tree pseudo-LRU: NUM_WAYS-1 node bits per set.
// A node bit of 1 points to the right subtree as the next victim.
module cache_plru_tree
  import cache_def::*;
#(
  parameter  int NUM_WAYS = 4,
  parameter  int NUM_SETS = 256,
  localparam int WW = $clog2(NUM_WAYS),
  localparam int IW = $clog2(NUM_SETS)
)(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_upd,
  input  logic [IW-1:0] i_set,
  input  logic [WW-1:0] i_way,
  output logic [WW-1:0] o_victim
);

  logic [NUM_WAYS-2:0] r_bits [NUM_SETS];
  logic [NUM_WAYS-2:0] w_cur;

  function automatic logic [NUM_WAYS-2:0] touch(
    input logic [NUM_WAYS-2:0] b,
    input logic [WW-1:0]       w
  );
    logic [NUM_WAYS-2:0] r;
    int n;
    r = b;
    n = 0;
    for (int l = 0; l < WW; l++) begin
      r[n] = ~w[WW-1-l];
      n = 2 * n + 1 + int'(w[WW-1-l]);
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] pick(
    input logic [NUM_WAYS-2:0] b
  );
    logic [WW-1:0] v;
    int n;
    v = '0;
    n = 0;
    for (int l = 0; l < WW; l++) begin
      v[WW-1-l] = b[n];
      n = 2 * n + 1 + int'(b[n]);
    end
    return v;
  endfunction

  assign w_cur    = r_bits[i_set];
  assign o_victim = pick(w_cur);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        r_bits[s] <= '0;
    end else if (i_upd) begin
      r_bits[i_set] <= touch(w_cur, i_way);
    end
  end

endmodule

// File: rtl/dcache_nway.sv
// Write-back, write-allocate n-way set-associative data cache.
// Define DCACHE_PERF_CNT_EN to build the access/hit/miss counters.
module dcache_nway
  import cache_def::*;
#(
  parameter int NUM_WAYS   = 4,
  parameter int NUM_SETS   = 256,
  parameter int LINE_WORDS = 4
)(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cpu_valid_i,
  input  logic                    cpu_rw_i,
  input  logic [31:0]             cpu_addr_i,
  input  logic [31:0]             cpu_wdata_i,
  input  logic [3:0]              cpu_be_i,
  output logic                    cpu_ready_o,
  output logic [31:0]             cpu_rdata_o,
  output logic                    mem_valid_o,
  output logic                    mem_rw_o,
  output logic [31:0]             mem_addr_o,
  output logic [32*LINE_WORDS-1:0] mem_wdata_o,
  input  logic                    mem_ready_i,
  input  logic [32*LINE_WORDS-1:0] mem_rdata_i,
  output logic [31:0]             no_acc_o,
  output logic [31:0]             no_hit_o,
  output logic [31:0]             no_miss_o
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_SETS);
  localparam int WW = $clog2(NUM_WAYS);
  localparam int TW = 30 - OW - IW;
  localparam int LB = 32 * LINE_WORDS;

  state_t              r_state, w_next;
  cpu_req_t            r_req;
  logic [WW-1:0]       r_victim;
  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
  logic [TW-1:0]       r_tag   [NUM_SETS][NUM_WAYS];
  logic [LB-1:0]       r_data  [NUM_SETS][NUM_WAYS];

  logic [TW-1:0]       w_tag;
  logic [IW-1:0]       w_idx;
  logic [OW-1:0]       w_off;
  logic [NUM_WAYS-1:0] w_hit_vec;
  logic                w_hit;
  logic [WW-1:0]       w_hit_way;
  logic                w_inv_any;
  logic [WW-1:0]       w_inv_way;
  logic [WW-1:0]       w_plru_way;
  logic [WW-1:0]       w_victim;
  logic [LB-1:0]       w_hit_line;
  logic [LB-1:0]       w_new_line;
  logic [31:0]         w_hit_word;
  logic                w_fill;
  logic                w_wr_hit;
  logic                w_unused;

  assign w_tag    = r_req.addr[31 -: TW];
  assign w_idx    = r_req.addr[2+OW +: IW];
  assign w_off    = r_req.addr[2 +: OW];
  assign w_unused = ^{r_req.addr[1:0], cpu_addr_i[1:0]};

  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    w_inv_any = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_hit_vec[w] = r_valid[w_idx][w] &&
                     (r_tag[w_idx][w] == w_tag);
      if (w_hit_vec[w]) w_hit_way = WW'(w);
    end
    // descending scan leaves the lowest invalid way
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_inv_any = 1'b1;
        w_inv_way = WW'(w);
      end
    end
  end

  assign w_hit      = |w_hit_vec;
  assign w_victim   = w_inv_any ? w_inv_way : w_plru_way;
  assign w_hit_line = r_data[w_idx][w_hit_way];
  assign w_hit_word = w_hit_line[32*int'(w_off) +: 32];

  always_comb begin
    w_new_line = w_hit_line;
    for (int b = 0; b < 4; b++) begin
      if (r_req.be[b])
        w_new_line[32*int'(w_off) + 8*b +: 8] = r_req.wdata[8*b +: 8];
    end
  end

  assign w_fill   = (r_state == S_ALLOCATE) && mem_ready_i;
  assign w_wr_hit = (r_state == S_COMPARE) && w_hit && r_req.rw;

  cache_plru_tree #(
    .NUM_WAYS (NUM_WAYS),
    .NUM_SETS (NUM_SETS)
  ) u_plru (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .i_upd    ((r_state == S_COMPARE) && w_hit),
    .i_set    (w_idx),
    .i_way    (w_hit_way),
    .o_victim (w_plru_way)
  );

  always_comb begin
    w_next      = r_state;
    cpu_ready_o = 1'b0;
    cpu_rdata_o = '0;
    mem_valid_o = 1'b0;
    mem_rw_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (r_state)
      S_IDLE: begin
        if (cpu_valid_i) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          cpu_ready_o = 1'b1;
          cpu_rdata_o = w_hit_word;
          w_next      = S_IDLE;
        end else if (r_dirty[w_idx][w_victim]) begin
          w_next = S_WRITE_BACK;
        end else begin
          w_next = S_ALLOCATE;
        end
      end
      S_WRITE_BACK: begin
        mem_valid_o = 1'b1;
        mem_rw_o    = 1'b1;
        mem_addr_o  = {r_tag[w_idx][r_victim], w_idx, {(OW+2){1'b0}}};
        mem_wdata_o = r_data[w_idx][r_victim];
        if (mem_ready_i) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = {w_tag, w_idx, {(OW+2){1'b0}}};
        if (mem_ready_i) w_next = S_COMPARE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_req    <= '0;
      r_victim <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cpu_valid_i)
        r_req <= '{cpu_rw_i, cpu_addr_i, cpu_wdata_i, cpu_be_i};
      if (r_state == S_COMPARE && !w_hit)
        r_victim <= w_victim;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else if (w_fill) begin
      r_valid[w_idx][r_victim] <= 1'b1;
      r_dirty[w_idx][r_victim] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_idx][w_hit_way] <= 1'b1;
    end
  end

  // line storage needs no reset: valid bits gate every use
  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_tag[w_idx][r_victim]  <= w_tag;
      r_data[w_idx][r_victim] <= mem_rdata_i;
    end else if (w_wr_hit) begin
      r_data[w_idx][w_hit_way] <= w_new_line;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic        r_first;
  logic [31:0] r_acc, r_hit, r_miss;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_first <= 1'b0;
      r_acc   <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
    end else begin
      if (r_state == S_IDLE && cpu_valid_i) begin
        r_acc   <= r_acc + 32'd1;
        r_first <= 1'b1;
      end
      if (r_state == S_COMPARE && r_first) begin
        r_first <= 1'b0;
        if (w_hit) r_hit  <= r_hit + 32'd1;
        else       r_miss <= r_miss + 32'd1;
      end
    end
  end

  assign no_acc_o  = r_acc;
  assign no_hit_o  = r_hit;
  assign no_miss_o = r_miss;
`else
  assign no_acc_o  = '0;
  assign no_hit_o  = '0;
  assign no_miss_o = '0;
`endif

endmodule

// File: doc/dcache_nway.md
DCACHE_NWAY -- requirements
Module: dcache_nway

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, ways per set (power of 2, >=2).
REQ-002 SHALL have parameter NUM_SETS, default 256, sets (power of 2, >=2).
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-004 SHALL have port clk_i  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cpu_valid_i  in  1  CPU request present.
REQ-007 SHALL have port cpu_rw_i  in  1  1=write, 0=read.
REQ-008 SHALL have port cpu_addr_i  in  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port cpu_wdata_i  in  32  write data.
REQ-010 SHALL have port cpu_be_i  in  4  byte enables for writes.
REQ-011 SHALL have port cpu_ready_o  out  1  one-cycle pulse: request complete.
REQ-012 SHALL have port cpu_rdata_o  out  32  read data, valid with cpu_ready_o.
REQ-013 SHALL have port mem_valid_o  out  1  memory line request.
REQ-014 SHALL have port mem_rw_o  out  1  1=line writeback, 0=line fill.
REQ-015 SHALL have port mem_addr_o  out  32  line-aligned address.
REQ-016 SHALL have port mem_wdata_o  out  32*LINE_WORDS  writeback line.
REQ-017 SHALL have port mem_ready_i  in  1  memory done; fill data valid same cycle.
REQ-018 SHALL have port mem_rdata_i  in  32*LINE_WORDS  fill line.
REQ-019 SHALL have ports no_acc_o, no_hit_o, no_miss_o  out  32 each  performance counters.

Function
REQ-020 SHALL be write-back, write-allocate, NUM_WAYS-way set-associative; address = tag | index(log2 NUM_SETS) | word offset(log2 LINE_WORDS) | byte(2).
REQ-021 SHALL run FSM IDLE, COMPARE, WRITE_BACK, ALLOCATE; IDLE->COMPARE when cpu_valid_i=1, latching the request.
REQ-022 COMPARE hit SHALL pulse cpu_ready_o that cycle (hit latency 1 cycle after acceptance), update pLRU, return to IDLE.
REQ-023 Write hit SHALL merge cpu_wdata_i per cpu_be_i into the line and set dirty.
REQ-024 COMPARE miss SHALL pick victim: lowest-index invalid way, else pLRU way; dirty victim -> WRITE_BACK, else -> ALLOCATE.
REQ-025 WRITE_BACK SHALL hold mem_valid_o=1, mem_rw_o=1, victim address/line until mem_ready_i, then ALLOCATE.
REQ-026 ALLOCATE SHALL hold mem_valid_o=1, mem_rw_o=0 until mem_ready_i, write line valid, clean, new tag, then COMPARE (which hits).
REQ-027 Memory outputs SHALL stay stable while mem_valid_o=1 and mem_ready_i=0; mem_valid_o SHALL be 0 in IDLE/COMPARE.
REQ-028 Tree pLRU SHALL hold NUM_WAYS-1 bits per set; access points all nodes away from the accessed way.
REQ-029 no_acc_o SHALL increment on each IDLE->COMPARE; no_hit_o/no_miss_o on first COMPARE result only; re-COMPARE after fill SHALL NOT count; counters wrap at 2^32.
REQ-030 cpu_* inputs SHALL be ignored outside IDLE.

Reset
REQ-031 Reset SHALL clear all valid, dirty and pLRU bits, FSM to IDLE, counters to 0, cpu_ready_o=0, mem_valid_o=0, other outputs 0.
REQ-032 Reset mid-WRITE_BACK/ALLOCATE SHALL abandon the transaction; no partial line retained.

Configuration
REQ-033 Macro DCACHE_PERF_CNT_EN defined: counters implemented per REQ-029; undefined: counter registers absent, no_*_o tied to 0.

Structure
REQ-034 Shared package cache_def SHALL hold cpu/mem request/result typedefs and FSM state enum; widths derived from parameters in-module.
REQ-035 Sub-module cache_plru_tree (per-set tree-pLRU, parametrised NUM_WAYS, NUM_SETS) SHALL be instantiated once.

Verification
REQ-036 Cold read 0x0000_0100, mem returns line {4,3,2,1} -> one fill, cpu_rdata_o=1, no_miss_o=1, no_acc_o=1.
REQ-037 Read 0x104 afterwards -> cpu_ready_o one cycle after accept, data 2, no_hit_o=1, no mem_valid_o.
REQ-038 Write 0xAABBCCDD be=4'b0011 to 0x100 then read -> 0x0000CCDD (old data 0x00000001, upper bytes 0).
REQ-039 Fill NUM_WAYS+1 lines mapping to one set, victim dirty -> WRITE_BACK of victim line then ALLOCATE, victim = pLRU way.
REQ-040 mem_ready_i delayed 5 cycles -> mem_addr_o/mem_wdata_o stable throughout; rst_ni low mid-ALLOCATE -> IDLE, all lines invalid, counters 0.
